// File: rtl/cmd_parser_if.sv
// Shared-register read handshake and decoded write strobes
// for the display command parser.
interface cmd_parser_if;
    logic        has_data;
    logic [7:0]  rd_data;
    logic        rd;
    logic        color_wr;
    logic [1:0]  color_idx;
    logic [3:0]  color_val;
    logic        pal_wr;
    logic [3:0]  pal_addr;
    logic [11:0] pal_data;
    logic        reg_wr;
    logic [3:0]  reg_addr;
    logic [15:0] reg_data;
    logic        busy;
    logic [7:0]  err_count;

    // Parser side: reads bytes, drives strobes.
    modport master (
        input  has_data, rd_data,
        output rd, color_wr, color_idx, color_val,
        output pal_wr, pal_addr, pal_data,
        output reg_wr, reg_addr, reg_data,
        output busy, err_count
    );

    // Register/consumer side.
    modport slave (
        output has_data, rd_data,
        input  rd, color_wr, color_idx, color_val,
        input  pal_wr, pal_addr, pal_data,
        input  reg_wr, reg_addr, reg_data,
        input  busy, err_count
    );
endinterface

// File: rtl/cmd_parser.sv
// Multi-byte display command parser: colour, palette and
// control-register writes with argument timeout.
module cmd_parser #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000
) (
    input  logic         clk,
    input  logic         nrst,
    cmd_parser_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_ARG
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_more;
    logic        r_arg_cnt;
    logic        r_busy;
    logic [15:0] r_tcnt;
    logic [7:0]  r_op;
    logic [7:0]  r_arg1;

    logic        r_rd;
    logic        r_color_wr;
    logic [1:0]  r_color_idx;
    logic [3:0]  r_color_val;
    logic        r_pal_wr;
    logic [3:0]  r_pal_addr;
    logic [11:0] r_pal_data;
    logic        r_reg_wr;
    logic [3:0]  r_reg_addr;
    logic [15:0] r_reg_data;
    logic [7:0]  r_err;

    logic w_abort;
    logic w_accept;
    logic w_op_acc;
    logic w_arg_acc;
    logic w_final;
    logic w_multi;
    logic w_resv;

    assign w_abort   = (r_state == S_ARG) &&
                       (r_tcnt == TIMEOUT_CYCLES - 16'd1);
    assign w_accept  = bus.has_data && !w_abort &&
                       (r_state == S_IDLE || r_state == S_ARG);
    assign w_op_acc  = w_accept && (r_state == S_IDLE);
    assign w_arg_acc = w_accept && (r_state == S_ARG);
    assign w_final   = w_arg_acc && r_arg_cnt;
    assign w_multi   = w_op_acc && (bus.rd_data[7:6] == 2'b01 ||
                                    bus.rd_data[7:6] == 2'b10);
    assign w_resv    = w_op_acc && (bus.rd_data[7:6] == 2'b11);

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: every accepted byte is followed by one gap cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_GAP;
            S_GAP:  w_next = r_more ? S_ARG : S_IDLE;
            S_ARG: begin
                if (w_abort)       w_next = S_IDLE;
                else if (w_accept) w_next = S_GAP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command progress: argument count, byte latches, busy, timeout.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_more    <= 1'b0;
            r_arg_cnt <= 1'b0;
            r_busy    <= 1'b0;
            r_tcnt    <= 16'd0;
            r_op      <= 8'd0;
            r_arg1    <= 8'd0;
        end else begin
            if (w_op_acc) begin
                r_op      <= bus.rd_data;
                r_arg_cnt <= 1'b0;
                r_more    <= w_multi;
                r_busy    <= w_multi;
            end
            if (w_arg_acc) begin
                r_arg_cnt <= 1'b1;
                if (!r_arg_cnt) r_arg1 <= bus.rd_data;
                if (r_arg_cnt)  r_more <= 1'b0;
            end
            if (w_abort) begin
                r_more <= 1'b0;
                r_busy <= 1'b0;
            end
            if (r_state == S_GAP && !r_more) r_busy <= 1'b0;
            if (w_accept || r_state != S_ARG) r_tcnt <= 16'd0;
            else if (!bus.has_data)            r_tcnt <= r_tcnt + 16'd1;
        end
    end

    // Registered read ack, write strobes, held address/data, errors.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rd        <= 1'b0;
            r_color_wr  <= 1'b0;
            r_color_idx <= 2'd0;
            r_color_val <= 4'd0;
            r_pal_wr    <= 1'b0;
            r_pal_addr  <= 4'd0;
            r_pal_data  <= 12'd0;
            r_reg_wr    <= 1'b0;
            r_reg_addr  <= 4'd0;
            r_reg_data  <= 16'd0;
            r_err       <= 8'd0;
        end else begin
            r_rd       <= w_accept;
            r_color_wr <= 1'b0;
            r_pal_wr   <= 1'b0;
            r_reg_wr   <= 1'b0;
            if (w_op_acc && bus.rd_data[7:6] == 2'b00) begin
                r_color_wr  <= 1'b1;
                r_color_idx <= bus.rd_data[5:4];
                r_color_val <= bus.rd_data[3:0];
            end
            if (w_final && r_op[7:6] == 2'b01) begin
                r_pal_wr   <= 1'b1;
                r_pal_addr <= r_op[3:0];
                r_pal_data <= {r_arg1, bus.rd_data[3:0]};
            end
            if (w_final && r_op[7:6] == 2'b10) begin
                r_reg_wr   <= 1'b1;
                r_reg_addr <= r_op[3:0];
                r_reg_data <= {bus.rd_data, r_arg1};
            end
            if ((w_resv || w_abort) && r_err != 8'hFF)
                r_err <= r_err + 8'd1;
        end
    end

    assign bus.rd        = r_rd;
    assign bus.color_wr  = r_color_wr;
    assign bus.color_idx = r_color_idx;
    assign bus.color_val = r_color_val;
    assign bus.pal_wr    = r_pal_wr;
    assign bus.pal_addr  = r_pal_addr;
    assign bus.pal_data  = r_pal_data;
    assign bus.reg_wr    = r_reg_wr;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_data  = r_reg_data;
    assign bus.busy      = r_busy;
    assign bus.err_count = r_err;
endmodule

// File: tb/tb_cmd_parser.sv
// Self-checking bench for cmd_parser: per-cycle model
// comparison plus directed literal checks.
module tb_cmd_parser;
    localparam int T = 16;

    logic clk;
    logic nrst;
    int   tests;
    int   fails;

    cmd_parser_if ifc ();

    cmd_parser #(.TIMEOUT_CYCLES(16'(T))) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    logic [7:0]  cmd [$];
    int          hold;
    int          wait_c;
    bit          fin;
    logic        e_rd, e_cw, e_pw, e_rw, e_busy;
    logic [1:0]  e_cidx;
    logic [3:0]  e_cval, e_paddr, e_raddr;
    logic [11:0] e_pdata;
    logic [15:0] e_rdata;
    logic [7:0]  e_err;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Model: each accepted byte forces a one-cycle holdoff; a command
    // is completed, rejected or timed out from the byte list.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cmd.delete();
            hold = 0; wait_c = 0; fin = 0;
            e_rd = 0; e_cw = 0; e_pw = 0; e_rw = 0; e_busy = 0;
            e_cidx = 0; e_cval = 0; e_paddr = 0; e_raddr = 0;
            e_pdata = 0; e_rdata = 0; e_err = 0;
        end else begin
            e_rd = 0; e_cw = 0; e_pw = 0; e_rw = 0; fin = 0;
            if (hold > 0) begin
                hold--;
            end else if (cmd.size() > 0 && wait_c == T - 1) begin
                cmd.delete();
                e_err = sat_inc(e_err);
                wait_c = 0;
            end else if (ifc.has_data) begin
                e_rd = 1; hold = 1; wait_c = 0;
                cmd.push_back(ifc.rd_data);
                case (cmd[0][7:6])
                    2'b00: begin
                        e_cw = 1;
                        e_cidx = cmd[0][5:4];
                        e_cval = cmd[0][3:0];
                        cmd.delete();
                    end
                    2'b11: begin
                        e_err = sat_inc(e_err);
                        cmd.delete();
                    end
                    default: if (cmd.size() == 3) begin
                        if (cmd[0][7:6] == 2'b01) begin
                            e_pw = 1;
                            e_paddr = cmd[0][3:0];
                            e_pdata = {cmd[1], cmd[2][3:0]};
                        end else begin
                            e_rw = 1;
                            e_raddr = cmd[0][3:0];
                            e_rdata = {cmd[2], cmd[1]};
                        end
                        fin = 1;
                        cmd.delete();
                    end
                endcase
            end else if (cmd.size() > 0) begin
                wait_c++;
            end
            e_busy = (cmd.size() > 0) || fin;
        end
    end

    logic [54:0] act_v, exp_v;
    assign act_v = {ifc.rd, ifc.color_wr, ifc.color_idx, ifc.color_val,
                    ifc.pal_wr, ifc.pal_addr, ifc.pal_data,
                    ifc.reg_wr, ifc.reg_addr, ifc.reg_data,
                    ifc.busy, ifc.err_count};
    assign exp_v = {e_rd, e_cw, e_cidx, e_cval,
                    e_pw, e_paddr, e_pdata,
                    e_rw, e_raddr, e_rdata,
                    e_busy, e_err};

    int n_rd, n_cw, n_pw, n_rw;

    // Compare every cycle on the falling edge; also count strobes.
    always @(negedge clk) begin
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL cycle_model t=%0t got %h want %h",
                     $time, act_v, exp_v);
        end
        if (ifc.rd)       n_rd++;
        if (ifc.color_wr) n_cw++;
        if (ifc.pal_wr)   n_pw++;
        if (ifc.reg_wr)   n_rw++;
        if (ifc.rd && ifc.rd_data === 8'hxx) n_rd = n_rd;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit seen;
        seen = 0;
        repeat (gap) @(negedge clk);
        ifc.has_data = 1'b1;
        ifc.rd_data  = b;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (ifc.rd) seen = 1;
        end
        ifc.has_data = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL rd_timeout byte %h got no rd want rd", b);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    int base_rd, base_cw, base_pw, base_rw;
    int r;
    logic [7:0] b;

    initial begin
        tests = 0; fails = 0;
        n_rd = 0; n_cw = 0; n_pw = 0; n_rw = 0;
        nrst = 1'b0;
        ifc.has_data = 1'b0;
        ifc.rd_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(act_v == 55'd0), 1);
        nrst = 1'b1;

        send(8'h2A, 2);
        repeat (2) @(negedge clk);
        chk("color_cnt", n_cw, 1);
        chk("color_idx", ifc.color_idx, 2);
        chk("color_val", ifc.color_val, 4'hA);
        chk("color_busy", ifc.busy, 0);

        send(8'h45, 1);
        chk("pal_busy", ifc.busy, 1);
        send(8'hF0, 1);
        send(8'h03, 1);
        repeat (3) @(negedge clk);
        chk("pal_cnt", n_pw, 1);
        chk("pal_addr", ifc.pal_addr, 5);
        chk("pal_data", ifc.pal_data, 12'hF03);
        chk("pal_rd_cnt", n_rd, 4);

        send(8'h87, 2);
        send(8'h34, 3);
        send(8'h12, 1);
        repeat (3) @(negedge clk);
        chk("reg_cnt", n_rw, 1);
        chk("reg_addr", ifc.reg_addr, 7);
        chk("reg_data", ifc.reg_data, 16'h1234);
        chk("reg_no_other", n_cw + n_pw, 2);

        send(8'h81, 1);
        send(8'hCD, 1);
        repeat (25) @(negedge clk);
        chk("tmo_err", ifc.err_count, 1);
        chk("tmo_no_reg", n_rw, 1);
        chk("tmo_busy", ifc.busy, 0);
        send(8'h13, 1);
        repeat (2) @(negedge clk);
        chk("tmo_next_cnt", n_cw, 2);
        chk("tmo_next_idx", ifc.color_idx, 1);
        chk("tmo_next_val", ifc.color_val, 3);

        base_rd = n_rd; base_cw = n_cw; base_pw = n_pw; base_rw = n_rw;
        for (int i = 0; i < 300; i++) send(8'hC0, 1);
        repeat (2) @(negedge clk);
        chk("resv_rd_cnt", n_rd - base_rd, 300);
        chk("resv_err_sat", ifc.err_count, 8'hFF);
        chk("resv_no_wr",
            (n_cw - base_cw) + (n_pw - base_pw) + (n_rw - base_rw), 0);

        send(8'h45, 1);
        send(8'hF0, 1);
        #3;
        nrst = 1'b0;
        #1;
        chk("async_reset", int'(act_v == 55'd0), 1);
        @(negedge clk);
        nrst = 1'b1;
        base_cw = n_cw; base_pw = n_pw;
        send(8'h01, 2);
        repeat (4) @(negedge clk);
        chk("post_rst_cw", n_cw - base_cw, 1);
        chk("post_rst_pw", n_pw - base_pw, 0);
        chk("post_rst_idx", ifc.color_idx, 0);
        chk("post_rst_val", ifc.color_val, 1);

        for (int i = 0; i < 400; i++) begin
            b = 8'($urandom);
            r = ($urandom_range(0, 19) == 0) ? T + 6 :
                int'($urandom_range(1, 4));
            send(b, r);
        end
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
- Consumes command bytes from the command shared register (has_data/rd/rd_data handshake) and decodes them into one-cycle register-write strobes.
- Targets: the 4-entry colour value array, a 16-entry 12-bit palette, and a 16-entry 16-bit control register file.
- Replaces the single-byte command processor in the display top level.
- Adds multi-byte commands, an argument timeout and a saturating error counter.

Parameters:
- TIMEOUT_CYCLES, 16'd60000, number of clk cycles allowed between bytes of one command before the command is aborted.

Ports:
- clk  in  1  system clock (120 MHz PLL clock via global buffer)
- nrst  in  1  reset, asynchronous, active-low
- has_data  in  1  shared register holds an unread byte
- rd_data  in  8  shared register byte; valid while has_data=1
- rd  out  1  one-cycle read acknowledge to the shared register
- color_wr  out  1  one-cycle strobe: colour value write
- color_idx  out  2  colour index
- color_val  out  4  colour value
- pal_wr  out  1  one-cycle strobe: palette write
- pal_addr  out  4  palette entry
- pal_data  out  12  {R[3:0],G[3:0],B[3:0]}
- reg_wr  out  1  one-cycle strobe: control register write
- reg_addr  out  4  control register number
- reg_data  out  16  control register value
- busy  out  1  high while a multi-byte command is in progress
- err_count  out  8  saturating count of bad or aborted commands

Behaviour:
- Reset (nrst=0, asynchronous): all outputs 0, state S_IDLE, internal byte latches and timeout counter 0.
- Byte acceptance:
  - A byte is accepted on a clk edge where has_data=1 and state is S_IDLE or S_ARG.
  - rd is high for exactly the following cycle.
  - State then passes through S_GAP for one cycle, so has_data is not sampled until 2 cycles after rd rose. This lets the shared register clear has_data.
  - rd is never high on two consecutive cycles.
- Opcode byte (first byte), field bits[7:6]:
  - 00 SET_COLOR: single byte. color_idx=b[5:4], color_val=b[3:0], color_wr high in the same cycle as rd.
  - 01 SET_PALETTE: pal_addr=b[3:0]; b[5:4] ignored; 2 argument bytes follow.
    - arg1 = {R,G}.
    - arg2 low nibble = B; arg2 high nibble ignored.
  - 10 SET_REG: reg_addr=b[3:0]; 2 argument bytes follow, low byte then high byte.
  - 11 reserved: byte consumed (rd pulses), no write, err_count increments.
- Multi-byte flow:
  - S_IDLE -> S_GAP -> S_ARG (arg_cnt=0) -> S_GAP -> S_ARG (arg_cnt=1) -> S_GAP -> S_IDLE.
  - busy=1 from the cycle after the opcode is accepted until the cycle after the final argument is accepted.
- Write timing:
  - On acceptance of the final argument byte, the write strobe and its data/address are valid in the same cycle as rd.
  - Strobe lasts exactly 1 cycle. Address/data outputs hold their last value afterwards.
  - At most one of color_wr/pal_wr/reg_wr is high in any cycle.
- Timeout:
  - In S_ARG, a 16-bit counter increments each cycle with has_data=0 and is cleared on each accepted byte.
  - When it reaches TIMEOUT_CYCLES-1, the command is aborted: state -> S_IDLE, busy->0, no write strobe, err_count increments.
  - A byte arriving later is parsed as a new opcode.
  - A byte arriving on the abort cycle itself is not accepted that cycle.
- err_count: increments by 1 per reserved opcode or timeout; saturates at 8'hFF with no wrap.
- No pacing: the parser does not qualify on the 40 MHz pixel tick. All writes occur at full clk rate; the consumer of the strobes handles pixel-domain timing.
- has_data falling without rd: tolerated. The parser only acts on sampled has_data=1.
- Reset mid-command: partial command discarded, no write strobe emitted, err_count cleared.

Test Plan:
- Reset, then byte 8'h2A -> rd pulse 1 cycle; in same cycle color_wr=1, color_idx=2, color_val=4'hA; busy stays 0.
- Bytes 8'h45, 8'hF0, 8'h03 -> three rd pulses each ≥2 cycles apart; pal_wr=1 once with pal_addr=5, pal_data=12'hF03; busy=1 between opcode and last arg.
- Bytes 8'h87, 8'h34, 8'h12 -> reg_wr=1 once, reg_addr=7, reg_data=16'h1234; no other strobe high.
- Byte 8'h81 then byte 8'hCD, then silence with TIMEOUT_CYCLES=16 -> abort 16 cycles after the 8'hCD acceptance; no reg_wr; err_count=1; next byte 8'h13 -> color_wr, idx 1, val 3.
- 300 bytes of 8'hC0 -> 300 rd pulses, no writes, err_count saturates at 8'hFF.
- Assert nrst mid-SET_PALETTE after arg1 -> all outputs 0 immediately (asynchronous); after release, byte 8'h01 -> color_wr, idx 0, val 1.
